// File: rtl/shift_reg_16.sv
// Parallel-load rotating register: loads a word on i_load, otherwise rotates
// one bit per clock in the direction chosen by i_dir.
module shift_reg_16 #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;

  // Each bit takes its neighbour below (left rotate) or above (right rotate),
  // with the ends wrapping around so no bit is ever lost.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      localparam int LO_SRC = (gi + WIDTH - 1) % WIDTH;
      localparam int HI_SRC = (gi + 1) % WIDTH;
      assign rot_left[gi]  = out_reg[LO_SRC];
      assign rot_right[gi] = out_reg[HI_SRC];
    end
  endgenerate

  always_comb begin
    out_next = out_reg;
    if (i_load) begin
      out_next = i_data;
    end else if (i_dir) begin
      out_next = rot_right;
    end else begin
      out_next = rot_left;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  assign o_out = out_reg;

endmodule

// File: tb/tb_shift_reg_16.sv
// Directed bench for shift_reg_16: reset, load, rotate both ways, wrap,
// asynchronous reset mid-rotation and repeated load.
module tb_shift_reg_16;

  logic        clk;
  logic        rst;
  logic        load;
  logic        dir;
  logic [15:0] data;
  logic [15:0] out;

  int compared   = 0;
  int mismatched = 0;

  shift_reg_16 #(.WIDTH(16)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (load),
    .i_dir  (dir),
    .i_data (data),
    .o_out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [15:0] exp, input string tag);
    compared++;
    assert (out === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, out, exp);
    end
    $display("%s: out=0x%04h exp=0x%04h", tag, out, exp);
  endtask

  task automatic tick(input logic [15:0] exp, input string tag);
    @(posedge clk);
    #1;
    check(exp, tag);
  endtask

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    dir  = 1'b0;
    data = 16'h0000;
    #3;
    check(16'h0000, "reset_async");
    tick(16'h0000, "reset_hold0");
    tick(16'h0000, "reset_hold1");
    rst = 1'b1;
    tick(16'h0000, "zero_rot0");
    tick(16'h0000, "zero_rot1");
    dir = 1'b1;
    tick(16'h0000, "zero_rot_r");

    // Rotate left from 0x8888
    load = 1'b1; dir = 1'b0; data = 16'h8888;
    tick(16'h8888, "l_load");
    load = 1'b0;
    tick(16'h1111, "l_rot1");
    tick(16'h2222, "l_rot2");
    tick(16'h4444, "l_rot3");
    tick(16'h8888, "l_rot4");

    // Rotate right from 0x8888
    load = 1'b1; dir = 1'b1; data = 16'h8888;
    tick(16'h8888, "r_load");
    load = 1'b0;
    tick(16'h4444, "r_rot1");
    tick(16'h2222, "r_rot2");
    tick(16'h1111, "r_rot3");
    tick(16'h8888, "r_rot4");

    // Wrap-around at both ends
    load = 1'b1; dir = 1'b0; data = 16'h8001;
    tick(16'h8001, "wrap_load_l");
    load = 1'b0;
    tick(16'h0003, "wrap_l");
    load = 1'b1; dir = 1'b1;
    tick(16'h8001, "wrap_load_r");
    load = 1'b0;
    tick(16'hC000, "wrap_r");

    // Asynchronous reset between edges
    load = 1'b1; dir = 1'b0; data = 16'h1234;
    tick(16'h1234, "rst_load");
    load = 1'b0;
    tick(16'h2468, "rst_rot");
    #2;
    rst = 1'b0;
    #1;
    check(16'h0000, "rst_midcycle");
    tick(16'h0000, "rst_held");
    rst = 1'b1;
    tick(16'h0000, "rst_released");
    load = 1'b1; data = 16'h1234;
    tick(16'h1234, "rst_reload");

    // Held load ignores direction
    load = 1'b1; data = 16'hA5A5; dir = 1'b0;
    tick(16'hA5A5, "hold_load0");
    dir = 1'b1;
    tick(16'hA5A5, "hold_load1");
    dir = 1'b0;
    tick(16'hA5A5, "hold_load2");
    dir = 1'b1;
    tick(16'hA5A5, "hold_load3");
    load = 1'b0;
    tick(16'hD2D2, "release_r");
    dir = 1'b0;
    tick(16'hA5A5, "dir_change_l");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
